// File: rtl/decoder_pkg.sv
// Shared constants for the 2-to-4 decoder family and its 4-to-2 return encoder.
package decoder_pkg;

  localparam int unsigned N_LINES = 4;

  localparam logic [1:0] CODE_Y1 = 2'b00;
  localparam logic [1:0] CODE_Y2 = 2'b01;
  localparam logic [1:0] CODE_Y3 = 2'b10;
  localparam logic [1:0] CODE_Y4 = 2'b11;

  localparam logic [1:0] LINE_CODE [N_LINES] = '{CODE_Y1, CODE_Y2, CODE_Y3, CODE_Y4};

  localparam bit PICK_FIXED = 1'b0;
  localparam bit PICK_RR    = 1'b1;

endpackage

// File: rtl/encoder4_seq_prio_pick4.sv
// Rotating priority picker: first set bit of pend searching upward from start, wrapping.
module prio_pick4
  import decoder_pkg::*;
(
  input  logic [N_LINES-1:0] pend,
  input  logic [1:0]         start,
  output logic [1:0]         idx,
  output logic               any
);

  logic [1:0] j;

  always_comb begin
    idx = '0;
    j   = '0;
    any = |pend;
    // Walk offsets high to low so the smallest offset from start is the last write.
    for (int unsigned k = N_LINES; k > 0; k--) begin
      j = start + 2'(k - 1);
      if (pend[j]) idx = j;
    end
  end

endmodule

// File: rtl/encoder4_seq.sv
// Registered 4-to-2 request encoder with pending set, valid/ready output slot and sticky overflow.
module encoder4_seq
  import decoder_pkg::*;
#(
  parameter bit EDGE_DET = 1'b1,
  parameter bit RR_EN    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic e,
  input  logic rdy,
  output logic a,
  output logic b,
  output logic v,
  output logic ovf
);

  localparam bit MODE = RR_EN ? PICK_RR : PICK_FIXED;

  logic [N_LINES-1:0] d_vec, d_q, evt;
  logic [N_LINES-1:0] pend_q, pend_d;
  logic [N_LINES-1:0] win_oh, slot_hit, drop;
  logic [1:0]         last_q, last_d, code_q, code_d;
  logic [1:0]         start, pick_idx;
  logic               v_q, v_d, ovf_q, ovf_d;
  logic               pick_any, load;

  assign d_vec = {d4, d3, d2, d1};
  assign evt   = EDGE_DET ? (d_vec & ~d_q) : d_vec;
  assign start = (MODE == PICK_RR) ? last_q + 2'd1 : '0;

  prio_pick4 u_pick (
    .pend  (pend_q),
    .start (start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign load = e & (~v_q | rdy) & pick_any;

  always_comb begin
    win_oh   = '0;
    slot_hit = '0;
    drop     = '0;
    pend_d   = '0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      win_oh[i]   = load && (pick_idx == LINE_CODE[i]);
      slot_hit[i] = v_q && (code_q == LINE_CODE[i]);
      // A fresh event on the bit being granted re-arms it instead of overflowing.
      drop[i]     = evt[i] & ~win_oh[i] & (pend_q[i] | slot_hit[i]);
      pend_d[i]   = e & ((pend_q[i] & ~win_oh[i]) | (evt[i] & ~drop[i]));
    end
  end

  always_comb begin
    ovf_d  = e & (ovf_q | (|drop));
    code_d = code_q;
    v_d    = v_q;
    last_d = last_q;
    if (!e) begin
      v_d = 1'b0;
    end else if (load) begin
      code_d = pick_idx;
      v_d    = 1'b1;
      last_d = pick_idx;
    end else if (v_q && rdy) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= '0;
      pend_q <= '0;
      last_q <= 2'd3;
      code_q <= '0;
      v_q    <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      d_q    <= d_vec;
      pend_q <= pend_d;
      last_q <= last_d;
      code_q <= code_d;
      v_q    <= v_d;
      ovf_q  <= ovf_d;
    end
  end

  assign a   = code_q[1];
  assign b   = code_q[0];
  assign v   = v_q;
  assign ovf = ovf_q;

endmodule
